// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    // Wait-state counter width; holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage: synchronous byte-masked write, combinational read.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write of the enabled lanes.
    // NOTE: storage has no reset; clearing a RAM costs a port per word and
    // software never relies on power-up contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory on the responder side of the load/store port: one request at a
// time, configurable wait states, registered response with error flag.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD  =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              accept;
    logic              fire;
    logic              acc_write;
    logic [31:0]       acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [STRB_W-1:0] acc_wstrb;
    logic              addr_ok;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign accept = (state == IDLE) && req_ready && req_valid;

    // The access happens either on the acceptance edge (no wait states) or
    // on the edge where the wait counter has run out.
    assign fire = (accept && (WAIT_CYCLES == 0)) ||
                  ((state == WAIT) && (cnt == '0));

    // With zero wait states the access uses the live request, otherwise the
    // captured copy.
    assign acc_write = (state == IDLE) ? req_write : write_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_wstrb = (state == IDLE) ? req_wstrb : wstrb_q;

    assign addr_ok = (acc_addr[1:0] == 2'b00) && (acc_addr[31:2] < DEPTH_LIM);
    assign mem_we  = fire && acc_write && addr_ok;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_we),
        .idx     (acc_addr[IDX_W+1:2]),
        .wr_data (acc_wdata),
        .wr_strb (acc_wstrb),
        .rd_data (mem_rdata)
    );

    // Request/response FSM with registered handshake outputs.
    // NOTE: state and outputs use non-blocking assignments so every read in
    // this block sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        // First edge out of reset.
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        req_ready <= 1'b0;
                        cnt       <= CNT_LOAD;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Completing the access overrides the transition chosen above.
            if (fire) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= !addr_ok;
                rsp_rdata <= (!acc_write && addr_ok) ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: DUT 0 has two wait states, DUT 1 has none.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_write (req_write[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_wstrb (req_wstrb[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_write (req_write[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_wstrb (req_wstrb[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // req_ready and rsp_valid must never be high together.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_valid_excl0", 32'(req_ready[0] && rsp_valid[0]), 32'd0);
            check("ready_valid_excl1", 32'(req_ready[1] && rsp_valid[1]), 32'd0);
        end
    end

    // Full transaction with rsp_ready held high; returns data, error and the
    // number of negedges after acceptance until rsp_valid is seen.
    task automatic txn(input int w, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err, output int lat);
        int budget;
        @(negedge clk);
        req_valid[w] = 1'b1;
        req_write[w] = wr;
        req_addr[w]  = addr;
        req_wdata[w] = wdata;
        req_wstrb[w] = strb;
        rsp_ready[w] = 1'b1;
        budget = 0;
        while (!req_ready[w] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("req_ready_wait", 32'(req_ready[w]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[w] = 1'b0;
        lat = 1;
        while (!rsp_valid[w] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[w];
        err   = rsp_err[w];
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid_drop", 32'(rsp_valid[w]), 32'd0);
        check("req_ready_back", 32'(req_ready[w]), 32'd1);
    endtask

    // Issue a request on DUT 0 with rsp_ready low and return once accepted.
    task automatic issue0(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        int budget;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = wr;
        req_addr[0]  = addr;
        req_wdata[0] = wdata;
        req_wstrb[0] = strb;
        rsp_ready[0] = 1'b0;
        budget = 0;
        while (!req_ready[0] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("issue_ready_wait", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
    endtask

    task automatic wait_rsp0();
        int budget;
        budget = 0;
        while (!rsp_valid[0] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("rsp_valid_wait", 32'(rsp_valid[0]), 32'd1);
    endtask

    // Assert reset mid-cycle, check outputs, release and check ready timing.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
        check("rst_req_ready1", 32'(req_ready[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rel_req_ready_low", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        check("rel_req_ready_high", 32'(req_ready[0]), 32'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_cyc [$];

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0012, 32'h1111_1111, 4'hF, 32'h0,         1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0400, 32'h2222_2222, 4'hF, 32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0014, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
        vecs[11] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h0102_0304, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'hA, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'hAA02_CC04, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
        vecs[16] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0};
        vecs[18] = '{1'b1, 32'h0000_0020, 32'h5555_5555, 4'hF, 32'h0,         1'b0};

        for (int w = 0; w < 2; w++) begin
            req_valid[w] = 1'b0;
            req_write[w] = 1'b0;
            req_addr[w]  = '0;
            req_wdata[w] = '0;
            req_wstrb[w] = '0;
            rsp_ready[w] = 1'b0;
        end
        rst_n = 1'b0;
        #2;
        do_reset();

        // Table-driven transactions on the two-wait-state DUT.
        for (int i = 0; i < 19; i++) begin
            txn(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Stalled response: outputs hold, req_valid is ignored.
        issue0(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp0();
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = (k % 2 == 0);
            req_write[0] = 1'b1;
            req_addr[0]  = 32'h10;
            req_wdata[0] = 32'h0;
            req_wstrb[0] = 4'hF;
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            check("stall_rdata", rsp_rdata[0], 32'hDEAD_BEAA);
            check("stall_req_ready", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(rsp_valid[0]), 32'd0);
        check("stall_release_rdata", rsp_rdata[0], 32'd0);
        check("stall_release_err", 32'(rsp_err[0]), 32'd0);
        check("stall_release_ready", 32'(req_ready[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_queued_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("after_stall_load", rd, 32'hDEAD_BEAA);

        // Reset during WAIT discards the pending store.
        issue0(1'b1, 32'h20, 32'h1234_5678, 4'hF);
        do_reset();
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("rst_wait_load", rd, 32'h5555_5555);
        check("rst_wait_err", 32'(er), 32'd0);

        // Reset during RESP drops the response but keeps the committed store.
        issue0(1'b1, 32'h24, 32'h7777_7777, 4'hF);
        wait_rsp0();
        do_reset();
        check("rst_resp_valid", 32'(rsp_valid[0]), 32'd0);
        txn(0, 1'b0, 32'h24, 32'h0, 4'h0, rd, er, lat);
        check("rst_resp_load", rd, 32'h7777_7777);

        // Zero-wait-state DUT.
        txn(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check("w0_store_latency", 32'(lat), 32'd1);
        check("w0_store_err", 32'(er), 32'd0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("w0_load_rdata", rd, 32'hDEAD_BEEF);
        check("w0_load_latency", 32'(lat), 32'd1);

        // Back-to-back loads with rsp_ready tied high: one every 2 cycles.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h10;
        rsp_ready[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (req_valid[1] && req_ready[1]) acc_cyc.push_back(c);
            if (rsp_valid[1]) check("b2b_rdata", rsp_rdata[1], 32'hDEAD_BEEF);
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        check("b2b_count", 32'(acc_cyc.size()), 32'd6);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
